uart_transmitter: RTL
=====================

# uart_transmitter

Serial transmit stage for the UART link. It directly feeds the receive stage's `data_in` line. Bytes enter through a valid/ready handshake into a small FIFO. Each byte is then serialised onto `tx` as a start bit, 8 data bits LSB-first, even parity and a stop bit, advancing one bit period per `enable` tick. The same baud tick drives the receive stage, and the frame schedule is matched to its sampling sequence.

## Interface
- `FIFO_DEPTH`, 4: word buffer depth; power of two, ≥2.
- `PAR_TICKS`, 2: bit periods the parity level is held; 2 aligns with the receive stage's one idle sample slot after data bit 7.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `enable`  in  1  baud tick; one bit period per asserted cycle.
- `data_valid`  in  1  producer offers `data_in`.
- `data_in`  in  8  byte to transmit.
- `data_ready`  out  1  FIFO not full; push occurs when `data_valid && data_ready`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  frame in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words buffered.

## Operation
- Reset (`rst`=0 at a clk edge) drives `tx`=1, `busy`=0, `data_ready`=1 and `fifo_count`=0, and puts the FSM in IDLE.
  - The FIFO is flushed.
  - Reset overrides every other input, including mid-frame.
- `data_in` is sampled only on a push. Once popped, the word is held in an internal shift register, so the producer may change `data_in` freely afterwards.
- Parity bit = XOR of the 8 data bits, i.e. even parity: the 8 data bits plus the parity bit contain an even number of ones.
- FSM states: IDLE, START, DATA, PAR, STOP. All transitions happen only on cycles with `enable`=1.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop, load the shifter, compute parity, drive `tx`=0 and go to START.
  - START: drive d0 and go to DATA with bit count 1.
  - DATA: drive d[count] and increment count. After d7 is driven, drive parity and go to PAR.
  - PAR: hold parity for `PAR_TICKS` ticks in total, then drive `tx`=1 and go to STOP.
  - STOP: if the FIFO is non-empty, pop and drive `tx`=0 (back-to-back frame, START). Otherwise go to IDLE with `tx`=1.
- `busy` = 1 in every state except IDLE. It stays 1 across back-to-back frames.
- Boundary conditions:
  - Push while full: not accepted, because `data_ready`=0.
  - Push and pop in the same cycle: both take effect and `fifo_count` is unchanged.
  - Pop from an empty FIFO never occurs.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `enable` low: the FSM and `tx` are frozen. Pushes still proceed.

## Timing
- `tx`, `busy`, `fifo_count` and `data_ready` are registered and update on the clk edge where the event occurs.
- Each line level lasts exactly one `enable` interval.
- Frame length = 10 + `PAR_TICKS` ticks (12 by default). Level sequence: 0, d0…d7, parity × `PAR_TICKS`, 1.
- Latency from push into an empty idle block to the start bit on `tx`: the first `enable` tick at or after the cycle following the push.
- `enable` tied high is legal: one bit per cycle.
- The receive stage samples on the same ticks. It detects the start bit on tick k, samples d0…d7 on ticks k+1…k+8, skips tick k+9, samples parity on k+10 and the stop bit on k+11.

## Structure
- Package `uart_pkg` holds:
  - the `tx_state_t` enum (IDLE, START, DATA, PAR, STOP);
  - `DATA_W` = 8;
  - `PAR_TICKS_DEFAULT` = 2.
- Sub-module `uart_fifo`: synchronous FIFO, parameterised by `DATA_W` and `FIFO_DEPTH`. It provides push/pop/full/empty/count.
- The top level holds the FSM, the 3-bit data counter, the `PAR_TICKS` counter, the shifter and the parity register.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `enable`=1 and `data_valid`=1 → `tx`=1, `busy`=0, `data_ready`=1, `fifo_count`=0. No push is taken.
- Single byte: push 0xA5 with `enable` every 16 clks → `tx` per tick is 0 | 1 0 1 0 0 1 0 1 | 0 0 | 1, `busy` is high for 12 ticks, then the block returns to IDLE.
- Loopback: connect `tx` to the receive stage with a shared `enable`, push 0x00, 0xFF, 0x80, 0x37 back-to-back → the receive stage's `data_bus` shows each byte in order with `err`=0. There is no idle tick between frames.
- Full: with `enable`=0, offer 5 words → `data_ready` goes low after the 4th, `fifo_count`=4 and the 5th word is not taken. Then enable → exactly 4 frames are sent.
- Simultaneous push/pop: with `fifo_count`=1, push on the same cycle as the STOP→START pop → `fifo_count` stays 1 and frames continue back-to-back.
- Reset mid-frame: assert `rst`=0 during d3 → `tx`=1 on the next edge, `busy`=0, FIFO empty. A later push produces a clean 12-tick frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   DATA_W            - serialised word width
//   PAR_TICKS_DEFAULT - bit periods the parity level is held
//   tx_state_t        - transmit frame FSM states
//   even_parity       - parity bit that makes the 9-bit data+parity group even
package uart_pkg;

  localparam int unsigned DATA_W            = 8;
  localparam int unsigned PAR_TICKS_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte ingress handshake for the UART transmitter.
//   data_valid - producer offers data_in
//   data_in    - byte to transmit
//   data_ready - transmitter can accept (FIFO not full)
interface uart_transmitter_if;
  import uart_pkg::*;

  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;

  modport master (output data_valid, output data_in, input data_ready);
  modport slave  (input data_valid, input data_in, output data_ready);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous word FIFO with registered full/empty/count flags.
//   clk, rst  - clock, synchronous active-low reset (flushes the FIFO)
//   push_i    - write data_i (ignored while full)
//   pop_i     - advance read pointer (ignored while empty)
//   data_o    - word at the read pointer
//   full_o, empty_o, count_o - occupancy status
module uart_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              full_q;
  logic              empty_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array is not reset; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: FIFO-buffered bytes framed as start, 8 data bits
// LSB-first, even parity held PAR_TICKS periods, stop; one level per enable.
//   clk, rst   - clock, synchronous active-low reset
//   enable     - baud tick
//   bus        - byte ingress handshake (slave side)
//   tx         - serial line, idle high
//   busy       - frame in progress
//   fifo_count - words buffered
module uart_transmitter import uart_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PAR_TICKS  = PAR_TICKS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  uart_transmitter_if.slave           bus,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);
  localparam int unsigned PCNT_W    = $clog2(PAR_TICKS + 1);

  tx_state_t             state_q;
  logic [DATA_W-1:0]     shift_q;
  logic                  par_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [PCNT_W-1:0]     par_cnt_q;
  logic                  tx_q;
  logic                  busy_q;

  logic [DATA_W-1:0]     fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  // A new frame can only be launched from IDLE or at the end of a stop bit.
  assign fifo_pop = enable && !fifo_empty && ((state_q == IDLE) || (state_q == STOP));

  uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.data_valid),
    .data_i  (bus.data_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame sequencer; every transition is qualified by the baud tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      par_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (enable) begin
      unique case (state_q)
        IDLE, STOP: begin
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            par_q   <= even_parity(fifo_rdata);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end else begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        START: begin
          tx_q      <= shift_q[0];
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= BIT_CNT_W'(1);
          state_q   <= DATA;
        end
        DATA: begin
          // Count wraps to zero once d7 has been driven.
          if (bit_cnt_q == '0) begin
            tx_q      <= par_q;
            par_cnt_q <= PCNT_W'(1);
            state_q   <= PAR;
          end else begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        PAR: begin
          if (par_cnt_q == PCNT_W'(PAR_TICKS)) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            par_cnt_q <= par_cnt_q + PCNT_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx             = tx_q;
  assign busy           = busy_q;
  assign bus.data_ready = !fifo_full;

endmodule
